mc_decoder: RTL and testbench
=============================

Name: mc_decoder

Overview:
Multicycle control unit for the ARM-subset core, replacing the single-cycle decoder. It holds a Moore main FSM, a parametrised ALU decoder with an extended op set, and condition logic with an architectural NZCV flag register. It sits beside the datapath and reads instruction fields from the externally registered IR. It drives all mux selects and write enables, one micro-step per clock.

Parameters:
ALU_CTRL_W, 3, width of alu_control. 3 gives the full op set; 2 gives the legacy add/sub/and/orr/cmp set only.
FLAG_RESET, 4'b0000, reset value of the NZCV register, ordered {N,Z,C,V}.

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
cond  in  4  IR[31:28]
op  in  2  IR[27:26]
funct  in  6  IR[25:20]
rd  in  4  IR[15:12]
alu_flags  in  4  NZCV from the datapath ALU this cycle
pc_write  out  1  PC register enable
adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register
mem_w  out  1  data memory write
ir_write  out  1  IR enable
reg_w  out  1  register file write
result_src  out  2  00 = ALU register, 01 = data register, 10 = ALU direct
alu_src_a  out  1  0 = register A, 1 = PC
alu_src_b  out  2  00 = register B, 01 = extended immediate, 10 = constant 4
imm_src  out  2  00 = dp imm8, 01 = mem imm12, 10 = branch imm24
reg_src  out  2  [0] = PC as RA1 (branch), [1] = rd as RA2 (str)
alu_control  out  ALU_CTRL_W  ALU op select
flags  out  4  current NZCV register
illegal  out  1  sticky trap indicator (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. While reset=1: state=FETCH, flags=FLAG_RESET, illegal=0, and pc_write, ir_write, reg_w and mem_w are forced to 0.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, TRAP. Each state lasts one cycle.
- FETCH: adr_src=0, ir_write=1, alu_src_a=1, alu_src_b=10, alu_control=add, result_src=10, pc_write=1. Next state is DECODE.
- DECODE: alu_src_a=1, alu_src_b=10 (computes PC+8). reg_src is driven from op/funct. Next state:
  - op=01 → MEMADR
  - op=10 → BRANCH
  - op=00 with funct[5]=1 → EXECI; with funct[5]=0 → EXECR
  - op=11 → see Optional Feature
- MEMADR: alu_src_b=01, imm_src=01, add. Next state is MEMRD if funct[0]=1, otherwise MEMWR.
- MEMRD: adr_src=1. Next state is MEMWB.
- MEMWR: adr_src=1, mem_w=cond_ex. Next state is FETCH.
- MEMWB: result_src=01, reg_w=cond_ex. Next state is FETCH.
- EXECR: alu_src_b=00. EXECI: alu_src_b=01, imm_src=00. Both use the ALU decoder and go next to ALUWB.
- ALUWB: result_src=00, reg_w=cond_ex & ~no_write. Next state is FETCH.
- BRANCH: alu_src_b=01, imm_src=10, add, result_src=10, pc_write=cond_ex. Next state is FETCH.
- Writes to r15: in MEMWB or ALUWB with rd=15, reg_w=0 and pc_write=cond_ex.
- ALU decoder: cmd=funct[4:1], applied in EXECR, EXECI and ALUWB. All other states use add. Encodings:
  - add 0100 → 000
  - sub 0010 → 001
  - and 0000 → 010
  - orr 1100 → 011
  - eor 0001 → 100
  - mov 1101 → 101
  - cmp 1010 → 001
  - tst 1000 → 010
  - With ALU_CTRL_W=2, alu_control is truncated to the low 2 bits and eor/mov/tst are unsupported.
  - Unsupported cmd (without the trap): alu_control=add, no_write=1, no flag update.
- no_write=1 for cmp and tst.
- Flag write: flag_w[1] (NZ) = S bit (funct[0]) in ALUWB. flag_w[0] (CV) = flag_w[1] & (add|sub|cmp). cmp and tst update flags even when funct[0]=0.
- Flag update: in ALUWB, flags take alu_flags at the clock edge, only if cond_ex=1. Partial updates keep the unwritten bits.
- cond_ex is combinational from cond and the flags register:
  - 0000 EQ … 1101 LE per the ARM definitions
  - 1110 AL = 1
  - 1111 = 0
  - Flags written in ALUWB are visible to the next instruction's cond_ex.
- Latency: ldr 5 cycles, str 4, data-processing 4, branch 3.
- Reset mid-instruction abandons the instruction. No partial write occurs after reset is asserted.

Optional Feature:
MC_DECODER_ILLEGAL_TRAP_EN
- Defined: op=11 in DECODE, or an unsupported cmd in EXECR/EXECI, moves to TRAP.
  - TRAP drives all enables to 0, sets illegal=1 and stays in TRAP until reset.
  - Only reset clears illegal.
- Undefined:
  - op=11 in DECODE returns to FETCH (executes as a NOP).
  - An unsupported cmd completes through ALUWB with no register or flag write.
  - illegal is tied to 0 and the TRAP state does not exist.

Test Plan:
- Reset, then release → FETCH with ir_write=1, pc_write=1; flags=0000, illegal=0. Assert reset in DECODE → FETCH next cycle, no enables asserted.
- ADDS cond=1110 op=00 funct=101001 with alu_flags=0110 → states FETCH, DECODE, EXECI, ALUWB, FETCH. reg_w=1 in ALUWB; flags=0110 afterwards.
- CMP (funct=010101) with alu_flags=0100, then BEQ (cond=0000, op=10) → no reg_w on the CMP; pc_write=1 in BRANCH. Repeat with alu_flags=0000 → pc_write=0.
- LDR op=01 funct=011001 rd=3 → 5 cycles, adr_src=1 in MEMRD, result_src=01 and reg_w=1 in MEMWB. With rd=15 → reg_w=0, pc_write=1.
- STR (funct[0]=0) with cond=0001 (NE) and Z=1 → mem_w=0 in MEMWR, back to FETCH after 4 cycles.
- op=11 → with MC_DECODER_ILLEGAL_TRAP_EN: TRAP, illegal=1 held for 10+ cycles until reset. Without: DECODE→FETCH, no writes.

Source files
------------

// File: rtl/mc_decoder.sv
// mc_decoder: multicycle control unit for the ARM-subset core.
// Moore main FSM, ALU decoder and NZCV condition logic.
// Optional feature macro: MC_DECODER_ILLEGAL_TRAP_EN (illegal op/cmd -> sticky TRAP state).
module mc_decoder #(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter logic [3:0]  FLAG_RESET = 4'b0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            cond,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            rd,
  input  logic [3:0]            alu_flags,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_w,
  output logic                  ir_write,
  output logic                  reg_w,
  output logic [1:0]            result_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0]            flags,
  output logic                  illegal
);

  // eor/mov/tst only exist with the wide ALU control bus
  localparam bit FullOps = (ALU_CTRL_W >= 3);

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StAluWb,
    StBranch
`ifdef MC_DECODER_ILLEGAL_TRAP_EN
    , StTrap
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  flags_q;
  logic [3:0]  cmd;
  logic [2:0]  dec_op;
  logic        dec_ok, dec_nw, dec_arith;
  logic [2:0]  alu_sel;
  logic        cond_ex;
  logic        flag_w_nz, flag_w_cv;
  logic        n_f, z_f, c_f, v_f;

  assign cmd         = funct[4:1];
  assign flags       = flags_q;
  assign alu_control = alu_sel[ALU_CTRL_W-1:0];
  // RA1 = PC for branches, RA2 = rd for stores; stable for the whole instruction
  assign reg_src     = {(op == 2'b01) & ~funct[0], (op == 2'b10)};

  // ALU decoder: map cmd to ALU op and side-effect qualifiers
  always_comb begin
    dec_op    = 3'd0;
    dec_ok    = 1'b1;
    dec_nw    = 1'b0;
    dec_arith = 1'b0;
    case (cmd)
      4'b0100: begin dec_op = 3'd0; dec_arith = 1'b1; end                  // add
      4'b0010: begin dec_op = 3'd1; dec_arith = 1'b1; end                  // sub
      4'b0000: dec_op = 3'd2;                                              // and
      4'b1100: dec_op = 3'd3;                                              // orr
      4'b0001: begin dec_op = 3'd4; dec_ok = FullOps; end                  // eor
      4'b1101: begin dec_op = 3'd5; dec_ok = FullOps; end                  // mov
      4'b1010: begin dec_op = 3'd1; dec_nw = 1'b1; dec_arith = 1'b1; end   // cmp
      4'b1000: begin dec_op = 3'd2; dec_nw = 1'b1; dec_ok = FullOps; end   // tst
      default: dec_ok = 1'b0;
    endcase
    // unsupported cmd degrades to a flag-less, write-less add
    if (!dec_ok) begin
      dec_op    = 3'd0;
      dec_nw    = 1'b1;
      dec_arith = 1'b0;
    end
  end

  // Condition check against the architectural flags
  always_comb begin
    {n_f, z_f, c_f, v_f} = flags_q;
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // cmp/tst always write flags; other ops only with the S bit
  assign flag_w_nz = (state_q == StAluWb) & dec_ok & (funct[0] | dec_nw);
  assign flag_w_cv = flag_w_nz & dec_arith;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // NZCV register with independent NZ / CV write enables
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= FLAG_RESET;
    end else if (cond_ex) begin
      if (flag_w_nz) flags_q[3:2] <= alu_flags[3:2];
      if (flag_w_cv) flags_q[1:0] <= alu_flags[1:0];
    end
  end

`ifdef MC_DECODER_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky trap flag, set on entry to TRAP, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (state_d == StTrap) begin
      illegal_q <= 1'b1;
    end
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Next-state and Moore outputs per micro-step
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_w      = 1'b0;
    ir_write   = 1'b0;
    reg_w      = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_src    = 2'b00;
    alu_sel    = 3'd0;
    case (state_q)
      StFetch: begin
        adr_src    = 1'b0;
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_d    = StDecode;
      end
      StDecode: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op)
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          2'b00:   state_d = funct[5] ? StExecI : StExecR;
`ifdef MC_DECODER_ILLEGAL_TRAP_EN
          default: state_d = StTrap;
`else
          default: state_d = StFetch;
`endif
        endcase
      end
      StMemAdr: begin
        alu_src_b = 2'b01;
        imm_src   = 2'b01;
        state_d   = funct[0] ? StMemRd : StMemWr;
      end
      StMemRd: begin
        adr_src = 1'b1;
        state_d = StMemWb;
      end
      StMemWr: begin
        adr_src = 1'b1;
        mem_w   = cond_ex;
        state_d = StFetch;
      end
      StMemWb: begin
        result_src = 2'b01;
        // a load into r15 redirects the PC instead of the register file
        if (rd == 4'd15) pc_write = cond_ex;
        else             reg_w    = cond_ex;
        state_d = StFetch;
      end
      StExecR, StExecI: begin
        alu_sel = dec_op;
        if (state_q == StExecI) begin
          alu_src_b = 2'b01;
          imm_src   = 2'b00;
        end
`ifdef MC_DECODER_ILLEGAL_TRAP_EN
        state_d = dec_ok ? StAluWb : StTrap;
`else
        state_d = StAluWb;
`endif
      end
      StAluWb: begin
        alu_sel    = dec_op;
        result_src = 2'b00;
        if (rd == 4'd15) pc_write = cond_ex & ~dec_nw;
        else             reg_w    = cond_ex & ~dec_nw;
        state_d = StFetch;
      end
      StBranch: begin
        alu_src_b  = 2'b01;
        imm_src    = 2'b10;
        result_src = 2'b10;
        pc_write   = cond_ex;
        state_d    = StFetch;
      end
`ifdef MC_DECODER_ILLEGAL_TRAP_EN
      StTrap: state_d = StTrap;
`endif
      default: state_d = StFetch;
    endcase
    // no architectural write may escape while reset is held
    if (reset) begin
      pc_write = 1'b0;
      ir_write = 1'b0;
      reg_w    = 1'b0;
      mem_w    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_decoder.sv
// Directed self-checking bench for mc_decoder (default ALU_CTRL_W=3, FLAG_RESET=0000).
// Follows MC_DECODER_ILLEGAL_TRAP_EN to pick the expected illegal-op behaviour.
module tb_mc_decoder;

  logic       clk, reset;
  logic [3:0] cond, rd, alu_flags;
  logic [1:0] op;
  logic [5:0] funct;
  logic       pc_write, adr_src, mem_w, ir_write, reg_w, alu_src_a, illegal;
  logic [1:0] result_src, alu_src_b, imm_src, reg_src;
  logic [2:0] alu_control;
  logic [3:0] flags;
  logic [15:0] ctrl;
  int n_checks = 0;
  int n_errors = 0;

  mc_decoder #(.ALU_CTRL_W(3), .FLAG_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .pc_write(pc_write), .adr_src(adr_src), .mem_w(mem_w),
    .ir_write(ir_write), .reg_w(reg_w), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_src(reg_src), .alu_control(alu_control),
    .flags(flags), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctrl = {pc_write, adr_src, mem_w, ir_write, reg_w, result_src, alu_src_a,
                 alu_src_b, imm_src, 1'b0, alu_control};

  function automatic logic [15:0] cw(input logic pc, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] res,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic [2:0] alu);
    return {pc, adr, mw, irw, rw, res, sa, sb, imm, 1'b0, alu};
  endfunction

  localparam logic [15:0] FetchW  = cw(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00, 3'd0);
  localparam logic [15:0] DecW    = cw(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 3'd0);
  localparam logic [15:0] MemAdrW = cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 3'd0);
  localparam logic [15:0] MemRdW  = cw(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd0);
  localparam logic [15:0] IdleW   = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check the FETCH cycle, then present the next instruction's fields
  task automatic fetch(input string tag, input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r, input logic [3:0] af);
    @(negedge clk);
    check(tag, ctrl, FetchW);
    cond = c; op = o; funct = f; rd = r; alu_flags = af;
  endtask

  task automatic step(input string tag, input logic [15:0] exp);
    @(negedge clk);
    check(tag, ctrl, exp);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("rst_en", {pc_write, ir_write, reg_w, mem_w}, 4'b0000);
    check("rst_illegal", illegal, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cond = 4'hE; op = 2'b00; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
    #2;
    check("rst_en", {pc_write, ir_write, reg_w, mem_w}, 4'b0000);
    check("rst_flags", flags, 4'b0000);
    check("rst_illegal", illegal, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset asserted while in DECODE
    fetch("rst_fetch", 4'hE, 2'b00, 6'b101001, 4'd2, 4'b0000);
    step("rst_dec", DecW);
    pulse_reset();

    // ADDS imm, AL
    fetch("adds_f", 4'hE, 2'b00, 6'b101001, 4'd2, 4'b0110);
    step("adds_dec", DecW);
    check("adds_regsrc", reg_src, 2'b00);
    step("adds_execi", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 3'd0));
    step("adds_aluwb", cw(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 3'd0));

    // CMP sets Z, BEQ taken
    fetch("cmp1_f", 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
    check("adds_flags", flags, 4'b0110);
    step("cmp1_dec", DecW);
    step("cmp1_execr", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd1));
    step("cmp1_aluwb", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd1));
    fetch("beq1_f", 4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
    check("cmp1_flags", flags, 4'b0100);
    step("beq1_dec", DecW);
    check("beq_regsrc", reg_src, 2'b01);
    step("beq1_branch", cw(1, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b10, 3'd0));

    // CMP clears Z, BEQ not taken
    fetch("cmp2_f", 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0000);
    step("cmp2_dec", DecW);
    step("cmp2_execr", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd1));
    step("cmp2_aluwb", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd1));
    fetch("beq2_f", 4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
    check("cmp2_flags", flags, 4'b0000);
    step("beq2_dec", DecW);
    step("beq2_branch", cw(0, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b10, 3'd0));

    // LDR r3 then LDR r15
    fetch("ldr_f", 4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000);
    step("ldr_dec", DecW);
    check("ldr_regsrc", reg_src, 2'b00);
    step("ldr_memadr", MemAdrW);
    step("ldr_memrd", MemRdW);
    step("ldr_memwb", cw(0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 3'd0));
    fetch("ldrpc_f", 4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000);
    step("ldrpc_dec", DecW);
    step("ldrpc_memadr", MemAdrW);
    step("ldrpc_memrd", MemRdW);
    step("ldrpc_memwb", cw(1, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 3'd0));

    // TST: NZ written, CV kept
    fetch("tst_f", 4'hE, 2'b00, 6'b010001, 4'd0, 4'b0111);
    step("tst_dec", DecW);
    step("tst_execr", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd2));
    step("tst_aluwb", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd2));

    // STR NE with Z=1: no write
    fetch("strne_f", 4'h1, 2'b01, 6'b011000, 4'd4, 4'b0000);
    check("tst_flags", flags, 4'b0100);
    step("strne_dec", DecW);
    check("str_regsrc", reg_src, 2'b10);
    step("strne_memadr", MemAdrW);
    step("strne_memwr", cw(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd0));

    // STR AL: write
    fetch("stral_f", 4'hE, 2'b01, 6'b011000, 4'd4, 4'b0000);
    step("stral_dec", DecW);
    step("stral_memadr", MemAdrW);
    step("stral_memwr", cw(0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd0));

    // ADDS NE with Z=1: no register or flag write
    fetch("addsne_f", 4'h1, 2'b00, 6'b101001, 4'd2, 4'b1011);
    step("addsne_dec", DecW);
    step("addsne_execi", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 3'd0));
    step("addsne_aluwb", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd0));

    // EOR reg, no S: no flag write
    fetch("eor_f", 4'hE, 2'b00, 6'b000010, 4'd5, 4'b1111);
    check("addsne_flags", flags, 4'b0100);
    step("eor_dec", DecW);
    step("eor_execr", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd4));
    step("eor_aluwb", cw(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 3'd4));

    // ORR imm into r15: PC write instead of register write
    fetch("orrpc_f", 4'hE, 2'b00, 6'b111000, 4'd15, 4'b0000);
    check("eor_flags", flags, 4'b0100);
    step("orrpc_dec", DecW);
    step("orrpc_execi", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 3'd3));
    step("orrpc_aluwb", cw(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd3));

    // MOVS imm: NZ only
    fetch("movs_f", 4'hE, 2'b00, 6'b111011, 4'd6, 4'b1011);
    step("movs_dec", DecW);
    step("movs_execi", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 3'd5));
    step("movs_aluwb", cw(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 3'd5));

    // Unsupported cmd 0011 with S=1
    fetch("unsup_f", 4'hE, 2'b00, 6'b000111, 4'd7, 4'b0111);
    check("movs_flags", flags, 4'b1000);
    step("unsup_dec", DecW);
    step("unsup_execr", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd0));
`ifdef MC_DECODER_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      step("unsup_trap", IdleW);
      check("unsup_illegal", illegal, 1'b1);
    end
    pulse_reset();
    fetch("op11_f", 4'hE, 2'b11, 6'b000000, 4'd1, 4'b1111);
    check("reset_flags", flags, 4'b0000);
    step("op11_dec", DecW);
    for (int i = 0; i < 12; i++) begin
      step("op11_trap", IdleW);
      check("op11_illegal", illegal, 1'b1);
    end
    pulse_reset();
    fetch("post_trap_f", 4'hE, 2'b00, 6'b000000, 4'd0, 4'b0000);
`else
    step("unsup_aluwb", cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'd0));
    fetch("op11_f", 4'hE, 2'b11, 6'b000000, 4'd1, 4'b1111);
    check("unsup_flags", flags, 4'b1000);
    step("op11_dec", DecW);
    fetch("op11_next_f", 4'hE, 2'b00, 6'b000000, 4'd0, 4'b0000);
    check("op11_flags", flags, 4'b1000);
    check("op11_illegal", illegal, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
